// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider: request side drives operands
// and start, divider side returns the muxed result and status.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic signed [WIDTH-1:0] X;
    logic signed [WIDTH-1:0] Y;
    logic        [4:0]       ALU_Select;
    logic                    sign;
    logic                    start;
    logic signed [WIDTH-1:0] Z1;
    logic                    busy;
    logic                    done;

    modport master (
        output X, Y, ALU_Select, sign, start,
        input  Z1, busy, done
    );

    modport slave (
        input  X, Y, ALU_Select, sign, start,
        output Z1, busy, done
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, signed or unsigned, one quotient bit per falling
// clock edge; quotient or remainder is selected onto Z1 combinationally.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int unsigned CW      = $clog2(WIDTH);
    localparam logic [4:0]  REM_SEL = 5'b10011;

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
    logic [WIDTH-1:0] quo_res_q, rem_res_q;
    logic             xs_q, ys_q, dz_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_c, step_c, fix_c;

    logic [WIDTH-1:0] x_raw, y_raw, x_mag, y_mag;
    logic [WIDTH:0]   rem_sh;
    logic             sub_ok;
    logic [WIDTH-1:0] rem_nx, q_fix, r_fix;

    // State register
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = DIV;
            DIV:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control strobes and next values of the registered status outputs
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        load_c = 1'b0;
        step_c = 1'b0;
        fix_c  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                load_c = 1'b1;
                busy_d = 1'b1;
            end
            DIV: begin
                step_c = 1'b1;
                busy_d = 1'b1;
            end
            FIX: begin
                fix_c  = 1'b1;
                busy_d = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Magnitudes: 0x8000_0000 negates to itself, read as unsigned 2^31
    always_comb begin
        x_raw = bus.X;
        y_raw = bus.Y;
        x_mag = (bus.sign && x_raw[WIDTH-1]) ? WIDTH'(0) - x_raw : x_raw;
        y_mag = (bus.sign && y_raw[WIDTH-1]) ? WIDTH'(0) - y_raw : y_raw;
    end

    // One restoring step on a (WIDTH+1)-bit partial remainder, plus sign fix-up
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        sub_ok = (rem_sh >= {1'b0, dvs_q});
        rem_nx = sub_ok ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
        q_fix  = dz_q ? '1 : ((xs_q ^ ys_q) ? WIDTH'(0) - quo_q : quo_q);
        r_fix  = xs_q ? WIDTH'(0) - rem_q : rem_q;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            xs_q      <= 1'b0;
            ys_q      <= 1'b0;
            dz_q      <= 1'b0;
            quo_res_q <= '0;
            rem_res_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (load_c) begin
                cnt_q <= '0;
                quo_q <= x_mag;
                rem_q <= '0;
                dvs_q <= y_mag;
                xs_q  <= bus.sign & x_raw[WIDTH-1];
                ys_q  <= bus.sign & y_raw[WIDTH-1];
                dz_q  <= (y_raw == '0);
            end
            if (step_c) begin
                cnt_q <= cnt_q + CW'(1);
                quo_q <= {quo_q[WIDTH-2:0], sub_ok};
                rem_q <= rem_nx;
            end
            if (fix_c) begin
                quo_res_q <= q_fix;
                rem_res_q <= r_fix;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Z1   = (bus.ALU_Select == REM_SEL) ? rem_res_q : quo_res_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed checks of seq_divider: arithmetic cases, latency, reset abort,
// mid-operation disturbance and back-to-back starts.
module tb_seq_divider;
    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Start one operation, measure busy cycles, then read both results
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic sg, input logic [31:0] eq, input logic [31:0] er);
        int cyc;
        bit seen;
        @(posedge clk);
        bus.X = x; bus.Y = y; bus.sign = sg; bus.start = 1'b1;
        @(posedge clk);
        bus.start = 1'b0;
        cyc = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) cyc++;
            @(posedge clk);
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(cyc), 32'd34);
        bus.ALU_Select = 5'd0;
        #1 check({tag, "_q"}, bus.Z1, eq);
        bus.ALU_Select = 5'b10011;
        #1 check({tag, "_r"}, bus.Z1, er);
        bus.ALU_Select = 5'd0;
        @(posedge clk);
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int dones;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0;
        bus.X = '0; bus.Y = '0; bus.sign = 1'b0; bus.ALU_Select = 5'd0; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_z1", bus.Z1, 32'h0);
        rst_n = 1'b1;

        run_op("u100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2);
        run_op("sm100_7", 32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE);
        run_op("s100_m7", 32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2);
        run_op("u_dz",    32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678);
        run_op("s_dz",    32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678);
        run_op("s_ovf",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'h0);
        run_op("u_ovf",   32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h0,          32'h8000_0000);

        // Abort an operation partway through DIV
        @(posedge clk);
        bus.X = 32'd1000; bus.Y = 32'd3; bus.sign = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        bus.ALU_Select = 5'b10011;
        #1 check("pre_rst_z1", bus.Z1, 32'h8000_0000);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_z1", bus.Z1, 32'h0);
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        bus.ALU_Select = 5'd0;
        run_op("post_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

        // Restart attempt and operand changes while busy
        @(posedge clk);
        bus.X = 32'd1000; bus.Y = 32'd10; bus.sign = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (bus.done) dones++;
            if (i == 5) begin
                bus.X = 32'd77; bus.Y = 32'd5; bus.sign = 1'b1; bus.start = 1'b1;
            end else if (i == 6) begin
                bus.start = 1'b0;
            end
        end
        check("busy_dones", 32'(dones), 32'd1);
        bus.ALU_Select = 5'd0;
        #1 check("busy_q", bus.Z1, 32'd100);
        bus.ALU_Select = 5'b10011;
        #1 check("busy_r", bus.Z1, 32'd0);
        bus.ALU_Select = 5'd0;

        // start held high: back-to-back operations
        @(posedge clk);
        bus.X = 32'd50; bus.Y = 32'd5; bus.sign = 1'b0; bus.start = 1'b1;
        dones = 0;
        for (int i = 0; i < 75; i++) begin
            @(posedge clk);
            if (bus.done) dones++;
        end
        check("held_dones", 32'(dones), 32'd2);
        #1 check("held_q", bus.Z1, 32'd10);
        bus.start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!bus.busy && !bus.done) break;
            @(posedge clk);
        end
        check("held_idle", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
